// File: rtl/uio_bus_arbiter_if.sv
// Bus bundle for the two-requester UIO pad arbiter.
// The arbiter takes the slave view and the requesters/pads take the master view.
interface uio_bus_arbiter_if;
  logic [1:0] req;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [7:0] uio_in;
  logic [1:0] grant;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] rdata;
  logic       busy;

  modport master (
    output req, wdata0, wdata1, uio_in,
    input  grant, uio_out, uio_oe, rdata, busy
  );

  modport slave (
    input  req, wdata0, wdata1, uio_in,
    output grant, uio_out, uio_oe, rdata, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Two-requester arbiter for a shared UIO pad bus: fair alternation on contention,
// bounded bursts, and optional idle turnaround cycles after every grant.
module uio_bus_arbiter #(
  parameter int BURST_MAX   = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uio_bus_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);
  localparam logic [1:0] TURN_LOAD = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

  logic [1:0] rstSync_q;
  logic       rstInt_n;

  logic [1:0] state_q,     state_d;
  logic       owner_q,     owner_d;
  logic       lastOwner_q, lastOwner_d;
  logic [3:0] beatCnt_q,   beatCnt_d;
  logic [1:0] turnCnt_q,   turnCnt_d;
  logic [1:0] grant_q,     grant_d;
  logic [7:0] rdata_q;

  logic       ownerReq;
  logic       ownActive;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstInt_n  = rstSync_q[1];
  assign ownActive = (state_q == OWN);
  assign ownerReq  = owner_q ? bus.req[1] : bus.req[0];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    beatCnt_d   = beatCnt_q;
    turnCnt_d   = turnCnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // On contention the requester that did not own the bus last time wins.
          owner_d     = (bus.req == 2'b11) ? ~lastOwner_q : bus.req[1];
          lastOwner_d = owner_d;
          beatCnt_d   = 4'd0;
          state_d     = OWN;
        end
      end
      OWN: begin
        if (ownerReq) begin
          beatCnt_d = beatCnt_q + 4'd1;
        end
        if (!ownerReq || (beatCnt_q == BEAT_LAST)) begin
          state_d   = (TURN_CYCLES > 0) ? TURN : IDLE;
          turnCnt_d = TURN_LOAD;
        end
      end
      TURN: begin
        if (turnCnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          turnCnt_d = turnCnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    grant_d = 2'b00;
    if (state_d == OWN) begin
      grant_d = owner_d ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastOwner_q <= 1'b1;
      beatCnt_q   <= 4'd0;
      turnCnt_q   <= 2'd0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      beatCnt_q   <= beatCnt_d;
      turnCnt_q   <= turnCnt_d;
      grant_q     <= grant_d;
    end
  end

  // The pad input is only sampled while we are not driving the pads ourselves.
  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      rdata_q <= 8'h00;
    end else if (!ownActive) begin
      rdata_q <= bus.uio_in;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.uio_oe  = ownActive ? 8'hFF : 8'h00;
  assign bus.uio_out = ownActive ? (owner_q ? bus.wdata1 : bus.wdata0) : 8'h00;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: two configurations driven in lockstep
// and compared every cycle against a transaction-level reference model.
module tb_uio_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [7:0] uioIn;

  int checks;
  int failures;

  uio_bus_arbiter_if ifA ();
  uio_bus_arbiter_if ifB ();

  assign ifA.req    = req;
  assign ifA.wdata0 = wdata0;
  assign ifA.wdata1 = wdata1;
  assign ifA.uio_in = uioIn;
  assign ifB.req    = req;
  assign ifB.wdata0 = wdata0;
  assign ifB.wdata1 = wdata1;
  assign ifB.uio_in = uioIn;

  uio_bus_arbiter #(.BURST_MAX(4), .TURN_CYCLES(1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA.slave)
  );

  uio_bus_arbiter #(.BURST_MAX(1), .TURN_CYCLES(0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the bus, beats granted so far, idle cycles left.
  int         burstCfg [2] = '{4, 1};
  int         turnCfg  [2] = '{1, 0};
  int         mOwner   [2];
  int         mBeats   [2];
  int         mTurn    [2];
  int         mLast    [2];
  int         mSync    [2];
  logic [7:0] mRdata   [2];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mOwner[i] = -1;
      mBeats[i] = 0;
      mTurn[i]  = 0;
      mLast[i]  = 1;
      mSync[i]  = 0;
      mRdata[i] = 8'h00;
    end
  endtask

  task automatic modelEdge();
    bit padsFree;
    bit done;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (mSync[i] >= 2) begin
          padsFree = (mOwner[i] < 0);
          if (mOwner[i] < 0 && mTurn[i] == 0) begin
            if (req != 2'b00) begin
              if (req == 2'b11) mOwner[i] = 1 - mLast[i];
              else              mOwner[i] = req[1] ? 1 : 0;
              mLast[i]  = mOwner[i];
              mBeats[i] = 0;
            end
          end else if (mOwner[i] >= 0) begin
            done = 1'b0;
            if (req[mOwner[i]]) begin
              mBeats[i]++;
              if (mBeats[i] == burstCfg[i]) done = 1'b1;
            end else begin
              done = 1'b1;
            end
            if (done) begin
              mOwner[i] = -1;
              mTurn[i]  = turnCfg[i];
            end
          end else begin
            mTurn[i]--;
          end
          if (padsFree) mRdata[i] = uioIn;
        end
        if (mSync[i] < 2) mSync[i]++;
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] expGrant;
    logic [7:0] expOe;
    logic [7:0] expOut;
    logic       expBusy;
    for (int i = 0; i < 2; i++) begin
      expGrant = 2'b00;
      expOe    = 8'h00;
      expOut   = 8'h00;
      if (mOwner[i] >= 0) begin
        expGrant = (mOwner[i] == 1) ? 2'b10 : 2'b01;
        expOe    = 8'hFF;
        expOut   = (mOwner[i] == 1) ? wdata1 : wdata0;
      end
      expBusy = (mOwner[i] >= 0) || (mTurn[i] > 0);
      if (i == 0) begin
        checkVal("A.grant", {6'd0, ifA.grant}, {6'd0, expGrant});
        checkVal("A.oe",    ifA.uio_oe,        expOe);
        checkVal("A.out",   ifA.uio_out,       expOut);
        checkVal("A.rdata", ifA.rdata,         mRdata[i]);
        checkVal("A.busy",  {7'd0, ifA.busy},  {7'd0, expBusy});
      end else begin
        checkVal("B.grant", {6'd0, ifB.grant}, {6'd0, expGrant});
        checkVal("B.oe",    ifB.uio_oe,        expOe);
        checkVal("B.out",   ifB.uio_out,       expOut);
        checkVal("B.rdata", ifB.rdata,         mRdata[i]);
        checkVal("B.busy",  {7'd0, ifB.busy},  {7'd0, expBusy});
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] w0,
                               input logic [7:0] w1, input logic [7:0] u);
    req    = r;
    wdata0 = w0;
    wdata1 = w1;
    uioIn  = u;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic resetAsync();
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkOutput();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    modelReset();
    applyStimulus(2'b00, 8'h00, 8'h00, 8'h00);
    #1 checkOutput();
    tick(2);

    // Single requester held: bursts of four with turnaround, then regrant.
    rst_n = 1'b1;
    applyStimulus(2'b01, 8'hA5, 8'h5A, 8'h11);
    tick(2);
    checkVal("A.noGrantBeforeEdge3", {6'd0, ifA.grant}, 8'h00);
    tick(1);
    checkVal("A.firstGrant", {6'd0, ifA.grant}, 8'h01);
    tick(12);

    // Both requesting: strict alternation starting where the last grant left off.
    applyStimulus(2'b00, 8'hA5, 8'h5A, 8'h22);
    tick(6);
    applyStimulus(2'b11, 8'hC3, 8'h3C, 8'h22);
    tick(20);

    // Requester 1 drops its request after two beats.
    applyStimulus(2'b00, 8'h00, 8'h00, 8'h00);
    tick(6);
    applyStimulus(2'b10, 8'h01, 8'h77, 8'h00);
    tick(3);
    applyStimulus(2'b00, 8'h01, 8'h77, 8'h00);
    tick(4);

    // Pad input is frozen in rdata while the arbiter drives the pads.
    applyStimulus(2'b00, 8'h00, 8'h00, 8'h3C);
    tick(2);
    applyStimulus(2'b01, 8'h99, 8'h00, 8'h3C);
    tick(1);
    applyStimulus(2'b01, 8'h99, 8'h00, 8'hFF);
    tick(3);
    checkVal("A.rdataHeld", ifA.rdata, 8'h3C);
    applyStimulus(2'b00, 8'h99, 8'h00, 8'hFF);
    tick(2);
    checkVal("A.rdataReload", ifA.rdata, 8'hFF);
    tick(2);

    // Reset asserted mid-burst, then contention right after release.
    applyStimulus(2'b11, 8'h12, 8'h34, 8'h56);
    tick(3);
    resetAsync();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checkVal("A.grantAfterReset", {6'd0, ifA.grant}, 8'h01);
    tick(10);

    // Randomised traffic with requests held for random stretches.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3, 0) == 0) req = 2'($urandom_range(3, 0));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      uioIn  = 8'($urandom);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
